// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction buffer.
// A small circular FIFO of {pc, instr} pairs sits between fetch and decode.
// An interrupt FSM can override the decode view with an injected instruction.
// While injecting, the buffered work is held in place.
module fetch_decode_buffer #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h78000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   input  logic        if_done,
   input  logic        stall,
   input  logic        flush,
   input  logic        INT,
   input  logic [31:0] INT_INST,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_valid,
   output logic        if_stall,
   output logic        ACK
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      INJECT,
      WAIT_LOW
   } state_t;

   logic [63:0]   r_mem [DEPTH];
   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   state_t        r_state;
   logic          r_ack;

   logic          w_empty;
   logic          w_full;
   logic          w_enq;
   logic          w_deq;
   logic [63:0]   w_head;
   logic [31:0]   w_headPc;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_FULL);
   assign w_head   = r_mem[r_rdPtr];
   assign w_headPc = w_empty ? 32'h0 : w_head[63:32];

   // Fetch data is dropped while full or flushing; fetch holds if_done until accepted.
   assign w_enq = if_done && !w_full && !flush;

   // The FIFO only drains when it, not the injected instruction, is feeding decode.
   assign w_deq = (r_state != INJECT) && !w_empty && !stall;

   assign if_stall = w_full;
   assign ACK      = r_ack;

   // Entry storage; stale contents are harmless because the pointers and count gate visibility.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wrPtr] <= {if_pc, if_instr};
      end
   end

   // Pointer and occupancy bookkeeping; flush wipes everything and wins over enqueue/dequeue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_deq) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + CNT_ONE;
         end else if (!w_enq && w_deq) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Interrupt sequencing: inject once per INT assertion, pulse ACK when decode takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (INT) begin
                  r_state <= INJECT;
               end
            end
            INJECT: begin
               if (!stall) begin
                  r_state <= WAIT_LOW;
                  r_ack   <= 1'b1;
               end
            end
            WAIT_LOW: begin
               if (!INT) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Decode view: injected instruction overrides the FIFO head, an empty FIFO shows a NOP.
   always_comb begin
      id_instr = NOP_WORD;
      id_pc    = 32'h0;
      id_valid = 1'b0;
      if (r_state == INJECT) begin
         id_instr = INT_INST;
         id_pc    = w_headPc;
         id_valid = 1'b1;
      end else if (!w_empty) begin
         id_instr = w_head[31:0];
         id_pc    = w_head[63:32];
         id_valid = 1'b1;
      end
   end

endmodule
